// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: branch opcodes, FSM states, counter width.
package branch_sequencer_pkg;

  localparam int COUNT_W = 16;
  localparam int OPC_W   = 6;

  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'b001001;
  localparam logic [OPC_W-1:0] OP_BGT  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_BGTE = 6'b001011;
  localparam logic [OPC_W-1:0] OP_BLE  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_BLEQ = 6'b001101;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RESOLVE  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_HALTED   = 2'd3
  } state_t;

  function automatic logic is_branch(input logic [OPC_W-1:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BGT, OP_BGTE, OP_BLE, OP_BLEQ};
  endfunction

endpackage

// File: rtl/branch_sequencer_cond.sv
// Combinational branch condition: signed 32-bit compare selected by opcode.
// Non-branch opcodes always report not-taken.
module branch_cond
  import branch_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0]   i_opcode,
  input  logic signed [31:0] i_rs,
  input  logic signed [31:0] i_rt,
  output logic               o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BEQ:  o_taken = (i_rs == i_rt);
      OP_BNE:  o_taken = (i_rs != i_rt);
      OP_BGT:  o_taken = (i_rs >  i_rt);
      OP_BGTE: o_taken = (i_rs >= i_rt);
      OP_BLE:  o_taken = (i_rs <  i_rt);
      OP_BLEQ: o_taken = (i_rs <= i_rt);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Fetch PC sequencer: stalls fetch one cycle per branch, redirects and flushes on taken.
// Control outputs decode only registered state; counters saturate at all-ones.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int                   ADDRESS_WIDTH = 6,
  parameter logic [ADDRESS_WIDTH:0] RESET_PC    = '0
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dec_valid,
  input  logic [OPC_W-1:0]         dec_opcode,
  input  logic [15:0]              dec_imm,
  input  logic [ADDRESS_WIDTH:0]   dec_pc,
  input  logic signed [31:0]       rs_val,
  input  logic signed [31:0]       rt_val,
  input  logic                     fetch_ready,
  input  logic                     halt_req,
  output logic [ADDRESS_WIDTH:0]   pc,
  output logic                     fetch_en,
  output logic                     stall,
  output logic                     flush,
  output logic [COUNT_W-1:0]       br_count,
  output logic [COUNT_W-1:0]       taken_count
);

  localparam int PCW = ADDRESS_WIDTH + 1;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [PCW-1:0]        r_pc;
  logic [OPC_W-1:0]      r_br_opcode;
  logic [15:0]           r_br_imm;
  logic [PCW-1:0]        r_br_pc;
  logic signed [31:0]    r_br_rs;
  logic signed [31:0]    r_br_rt;
  logic [COUNT_W-1:0]    r_br_count;
  logic [COUNT_W-1:0]    r_taken_count;

  logic                  w_dec_branch;
  logic                  w_taken;
  logic [PCW-1:0]        w_imm_pc;
  logic [PCW-1:0]        w_target;
  logic [PCW-1:0]        w_seq_pc;

  assign w_dec_branch = dec_valid && is_branch(dec_opcode);

  branch_cond u_branch_cond (
    .i_opcode (r_br_opcode),
    .i_rs     (r_br_rs),
    .i_rt     (r_br_rt),
    .o_taken  (w_taken)
  );

  // Size cast of a signed operand sign-extends or truncates; both wrap modulo 2^PCW.
  assign w_imm_pc = PCW'($signed(r_br_imm));
  assign w_target = r_br_pc + w_imm_pc;
  assign w_seq_pc = r_br_pc + PCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    fetch_en    = 1'b0;
    stall       = 1'b1;
    flush       = 1'b0;
    case (r_state)
      ST_RUN: begin
        fetch_en = 1'b1;
        stall    = 1'b0;
        if (w_dec_branch) begin
          w_state_nxt = ST_RESOLVE;
        end else if (halt_req) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_RESOLVE: begin
        w_state_nxt = w_taken ? ST_REDIRECT : ST_RUN;
      end
      ST_REDIRECT: begin
        flush       = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_HALTED: begin
        if (!halt_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_br_opcode   <= '0;
      r_br_imm      <= '0;
      r_br_pc       <= '0;
      r_br_rs       <= '0;
      r_br_rt       <= '0;
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (fetch_ready) begin
            r_pc <= r_pc + PCW'(1);
          end
          // Operands are captured so decode may change freely while we resolve.
          if (w_dec_branch) begin
            r_br_opcode <= dec_opcode;
            r_br_imm    <= dec_imm;
            r_br_pc     <= dec_pc;
            r_br_rs     <= rs_val;
            r_br_rt     <= rt_val;
          end
        end
        ST_RESOLVE: begin
          r_pc <= w_taken ? w_target : w_seq_pc;
          if (r_br_count != '1) begin
            r_br_count <= r_br_count + COUNT_W'(1);
          end
          if (w_taken && (r_taken_count != '1)) begin
            r_taken_count <= r_taken_count + COUNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;

endmodule
